// File: rtl/attribute_number_parser_if.sv
// Character-stream handshake and result bus between the attribute tokenizer
// and the number parser.
interface attribute_number_parser_if #(
    parameter int VALUE_BITS = 10,
    parameter int CHAR_BITS  = 8,
    parameter int MAX_DIGITS = 6
);
    localparam int CNT_BITS = $clog2(MAX_DIGITS + 2);

    logic                  start;
    logic [CHAR_BITS-1:0]  char;
    logic                  char_valid;
    logic                  char_ready;
    logic                  done;
    logic                  error;
    logic                  overflow;
    logic                  is_hex;
    logic                  is_percent;
    logic [VALUE_BITS-1:0] value;
    logic [CNT_BITS-1:0]   digit_count;

    modport master (
        output start, char, char_valid,
        input  char_ready, done, error, overflow, is_hex, is_percent, value, digit_count
    );

    modport slave (
        input  start, char, char_valid,
        output char_ready, done, error, overflow, is_hex, is_percent, value, digit_count
    );
endinterface

// File: rtl/attribute_number_parser.sv
// HTML attribute value -> unsigned number: decimal, "px"/"%" suffixes, saturation.
// Hex ("#" prefix) parsing is built only when ATTRIBUTE_NUMBER_PARSER_HEX_EN is defined.
module attribute_number_parser #(
    parameter int VALUE_BITS = 10,
    parameter int CHAR_BITS  = 8,
    parameter int MAX_DIGITS = 6
) (
    input logic clock,
    input logic reset_n,
    attribute_number_parser_if.slave bus
);
    localparam int CNT_BITS = $clog2(MAX_DIGITS + 2);
    localparam int WIDE     = VALUE_BITS + 4;
    localparam logic [WIDE-1:0] MAX_VAL = {4'b0, {VALUE_BITS{1'b1}}};

    localparam logic [CHAR_BITS-1:0] CH_SP   = CHAR_BITS'(8'h20);
    localparam logic [CHAR_BITS-1:0] CH_QT   = CHAR_BITS'(8'h22);
    localparam logic [CHAR_BITS-1:0] CH_HASH = CHAR_BITS'(8'h23);
    localparam logic [CHAR_BITS-1:0] CH_PCT  = CHAR_BITS'(8'h25);
    localparam logic [CHAR_BITS-1:0] CH_0    = CHAR_BITS'(8'h30);
    localparam logic [CHAR_BITS-1:0] CH_9    = CHAR_BITS'(8'h39);
    localparam logic [CHAR_BITS-1:0] CH_GT   = CHAR_BITS'(8'h3E);
    localparam logic [CHAR_BITS-1:0] CH_P    = CHAR_BITS'(8'h70);
    localparam logic [CHAR_BITS-1:0] CH_X    = CHAR_BITS'(8'h78);

    typedef enum logic [2:0] {IDLE, FIRST, DEC, HEX, UNIT_P, SUF_END, DONE} state_t;

    state_t                state;
    logic                  ready_q, done_q, err_q, ovf_q, hex_q, pct_q;
    logic [VALUE_BITS-1:0] value_q;
    logic [CNT_BITS-1:0]   cnt_q;

    logic [CHAR_BITS-1:0]  c;
    logic                  is_dec, is_term, xfer, sat;
    logic [3:0]            dig;
    logic [WIDE-1:0]       dec_next, acc;
    logic [VALUE_BITS-1:0] val_d;
    logic [CNT_BITS-1:0]   cnt_d;

    assign c       = bus.char;
    assign xfer    = bus.char_valid & ready_q & ~bus.start;
    assign is_dec  = (c >= CH_0) && (c <= CH_9);
    assign is_term = (c == CH_SP) || (c == CH_GT) || (c == CH_QT);

`ifdef ATTRIBUTE_NUMBER_PARSER_HEX_EN
    localparam logic [CHAR_BITS-1:0] CH_LA = CHAR_BITS'(8'h61);
    localparam logic [CHAR_BITS-1:0] CH_LF = CHAR_BITS'(8'h66);
    localparam logic [CHAR_BITS-1:0] CH_UA = CHAR_BITS'(8'h41);
    localparam logic [CHAR_BITS-1:0] CH_UF = CHAR_BITS'(8'h46);
    logic            is_hexd;
    logic [WIDE-1:0] hex_next;
    assign is_hexd  = is_dec || ((c >= CH_LA) && (c <= CH_LF)) || ((c >= CH_UA) && (c <= CH_UF));
    // Both 'a'..'f' and 'A'..'F' have low nibble 1..6, so +9 maps them to 10..15.
    assign dig      = is_dec ? c[3:0] : c[3:0] + 4'd9;
    assign hex_next = {value_q, 4'b0} | WIDE'(dig);
    assign acc      = (state == HEX) ? hex_next : dec_next;
`else
    assign dig      = c[3:0];
    assign acc      = dec_next;
`endif

    // Wide accumulate so a single step past the ceiling is visible before truncation.
    assign dec_next = WIDE'(value_q) * WIDE'(10) + WIDE'(dig);
    assign sat      = ovf_q || (cnt_q >= CNT_BITS'(MAX_DIGITS)) || (acc > MAX_VAL);
    assign val_d    = sat ? '1 : acc[VALUE_BITS-1:0];
    assign cnt_d    = (cnt_q == CNT_BITS'(MAX_DIGITS + 1)) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            hex_q   <= 1'b0;
            pct_q   <= 1'b0;
            value_q <= '0;
            cnt_q   <= '0;
        end else if (bus.start) begin
            state   <= FIRST;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            hex_q   <= 1'b0;
            pct_q   <= 1'b0;
            value_q <= '0;
            cnt_q   <= '0;
        end else if (xfer) begin
            case (state)
                FIRST: begin
                    if (is_dec) begin
                        state <= DEC; value_q <= val_d; ovf_q <= sat; cnt_q <= cnt_d;
`ifdef ATTRIBUTE_NUMBER_PARSER_HEX_EN
                    end else if (c == CH_HASH) begin
                        state <= HEX; hex_q <= 1'b1;
`endif
                    end else begin
                        state <= DONE; ready_q <= 1'b0; done_q <= 1'b1; err_q <= 1'b1;
                    end
                end
                DEC: begin
                    if (is_dec) begin
                        value_q <= val_d; ovf_q <= sat; cnt_q <= cnt_d;
                    end else if (c == CH_P) begin
                        state <= UNIT_P;
                    end else if (c == CH_PCT) begin
                        state <= SUF_END; pct_q <= 1'b1;
                    end else begin
                        state <= DONE; ready_q <= 1'b0; done_q <= 1'b1; err_q <= !is_term;
                    end
                end
`ifdef ATTRIBUTE_NUMBER_PARSER_HEX_EN
                HEX: begin
                    if (is_hexd) begin
                        value_q <= val_d; ovf_q <= sat; cnt_q <= cnt_d;
                    end else begin
                        state <= DONE; ready_q <= 1'b0; done_q <= 1'b1;
                        err_q <= !is_term || (cnt_q == '0);
                    end
                end
`endif
                UNIT_P: begin
                    if (c == CH_X) begin
                        state <= SUF_END;
                    end else begin
                        state <= DONE; ready_q <= 1'b0; done_q <= 1'b1; err_q <= 1'b1;
                    end
                end
                SUF_END: begin
                    state <= DONE; ready_q <= 1'b0; done_q <= 1'b1; err_q <= !is_term;
                end
                default: ;
            endcase
        end
    end

    assign bus.char_ready  = ready_q & ~bus.start;
    assign bus.done        = done_q;
    assign bus.error       = err_q;
    assign bus.overflow    = ovf_q;
    assign bus.is_hex      = hex_q;
    assign bus.is_percent  = pct_q;
    assign bus.value       = value_q;
    assign bus.digit_count = cnt_q;
endmodule

// File: tb/tb_attribute_number_parser.sv
// Self-checking bench for attribute_number_parser: vector table plus scoreboard,
// and hand-written stall / restart / async-reset sequences.
module tb_attribute_number_parser;
    localparam int VB = 10;
    localparam int CB = 8;
    localparam int MD = 6;
`ifdef ATTRIBUTE_NUMBER_PARSER_HEX_EN
    localparam bit HX = 1'b1;
`else
    localparam bit HX = 1'b0;
`endif

    typedef struct {
        string s;
        int    value;
        bit    err;
        bit    ovf;
        bit    hex;
        bit    pct;
        int    cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    attribute_number_parser_if #(.VALUE_BITS(VB), .CHAR_BITS(CB), .MAX_DIGITS(MD)) bus();

    attribute_number_parser #(.VALUE_BITS(VB), .CHAR_BITS(CB), .MAX_DIGITS(MD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        bus.start = 1'b1; bus.char_valid = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    // Offers each character until accepted; stops early once the parser finishes.
    task automatic feed(input string s);
        int g;
        for (int i = 0; i < s.len(); i++) begin
            g = 0;
            bus.char = s[i]; bus.char_valid = 1'b1;
            @(negedge clock);
            while (!bus.char_ready && !bus.done && g < 20) begin
                @(negedge clock); g++;
            end
            if (!bus.char_ready) break;
            @(posedge clock); #1;
        end
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 50) begin
            @(negedge clock); n++;
        end
        chk({tag, " done"}, bus.done, 1);
    endtask

    task automatic score(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, " value"},  bus.value,       e.value);
        chk({tag, " error"},  bus.error,       e.err);
        chk({tag, " ovf"},    bus.overflow,    e.ovf);
        chk({tag, " hex"},    bus.is_hex,      e.hex);
        chk({tag, " pct"},    bus.is_percent,  e.pct);
        chk({tag, " count"},  bus.digit_count, e.cnt);
        chk({tag, " ready"},  bus.char_ready,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.char = '0; bus.char_valid = 1'b0;
        #12;
        chk("rst done",  bus.done, 0);
        chk("rst ready", bus.char_ready, 0);
        chk("rst value", bus.value, 0);
        chk("rst count", bus.digit_count, 0);
        chk("rst flags", {bus.error, bus.overflow, bus.is_hex, bus.is_percent}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle ready", bus.char_ready, 0);

        vecs.push_back('{"640 ",     640,  0, 0, 0, 0, 3});
        vecs.push_back('{"50%>",     50,   0, 0, 0, 1, 2});
        vecs.push_back('{"12px ",    12,   0, 0, 0, 0, 2});
        vecs.push_back('{"2048 ",    1023, 0, 1, 0, 0, 4});
        vecs.push_back('{"1234567 ", 1023, 0, 1, 0, 0, 7});
        vecs.push_back('{"0000001 ", 1023, 0, 1, 0, 0, 7});
        vecs.push_back('{"1023\"",   1023, 0, 0, 0, 0, 4});
        vecs.push_back('{"1024>",    1023, 0, 1, 0, 0, 4});
        vecs.push_back('{"12q ",     12,   1, 0, 0, 0, 2});
        vecs.push_back('{">",        0,    1, 0, 0, 0, 0});
        vecs.push_back('{"3p5 ",     3,    1, 0, 0, 0, 1});
        vecs.push_back('{"9x ",      9,    1, 0, 0, 0, 1});
        vecs.push_back('{"5px5",     5,    1, 0, 0, 0, 1});
        vecs.push_back('{"#1aF ",    HX ? 431 : 0,  !HX, 0, HX, 0, HX ? 3 : 0});
        vecs.push_back('{"# ",       0,             1,   0, HX, 0, 0});
        vecs.push_back('{"#3FF ",    HX ? 1023 : 0, !HX, 0, HX, 0, HX ? 3 : 0});
        vecs.push_back('{"#400 ",    HX ? 1023 : 0, !HX, HX, HX, 0, HX ? 3 : 0});
        vecs.push_back('{"#g ",      0,             1,   0, HX, 0, 0});

        foreach (vecs[i]) begin
            pulse_start();
            exp_q.push_back(vecs[i]);
            feed(vecs[i].s);
            wait_done($sformatf("v%0d", i));
            score($sformatf("v%0d", i));
            if (i == 0) begin
                // DONE must hold its result while further characters are offered.
                bus.char = 8'h31; bus.char_valid = 1'b1;
                repeat (3) @(negedge clock);
                chk("hold done",  bus.done, 1);
                chk("hold value", bus.value, 640);
                chk("hold ready", bus.char_ready, 0);
                bus.char_valid = 1'b0;
            end
        end

        // Stall: idle cycles between digits change nothing.
        pulse_start();
        exp_q.push_back('{"1_7 ", 17, 0, 0, 0, 0, 2});
        feed("1");
        repeat (3) @(posedge clock);
        #1;
        chk("stall value", bus.value, 1);
        chk("stall ready", bus.char_ready, 1);
        feed("7 ");
        wait_done("stall");
        score("stall");

        // Restart mid-parse: start wins over a simultaneous transfer.
        pulse_start();
        feed("9");
        bus.char = 8'h39; bus.char_valid = 1'b1; bus.start = 1'b1;
        @(negedge clock);
        chk("restart ready", bus.char_ready, 0);
        @(posedge clock); #1;
        bus.start = 1'b0; bus.char_valid = 1'b0;
        chk("restart value", bus.value, 0);
        chk("restart count", bus.digit_count, 0);
        chk("restart done",  bus.done, 0);
        exp_q.push_back('{"4 ", 4, 0, 0, 0, 0, 1});
        feed("4 ");
        wait_done("restart");
        score("restart");

        // Asynchronous reset mid-parse clears outputs without a clock edge.
        pulse_start();
        feed("5%");
        #2 reset_n = 1'b0;
        #1;
        chk("arst value", bus.value, 0);
        chk("arst count", bus.digit_count, 0);
        chk("arst pct",   bus.is_percent, 0);
        chk("arst ready", bus.char_ready, 0);
        chk("arst done",  bus.done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("arst idle ready", bus.char_ready, 0);

        chk("queue empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
